// File: rtl/seg7_decoder_rx.sv
// seg7_decoder_rx: qualifies a sampled 7-segment pattern (plus overflow flag) after
// STABLE_N identical strobed samples and decodes it to a digit. The result is held
// in a one-entry valid/ready output register.
module seg7_decoder_rx #(
  parameter int unsigned STABLE_N = 3,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_en,
  input  logic [6:0] seg_in,
  input  logic       over_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_err,
  output logic       out_over,
  output logic       overrun
);

  localparam int unsigned KEY_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_N);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  state_t           state;
  logic [KEY_W-1:0] cand;
  logic [KEY_W-1:0] last_rep;
  logic [CNT_W-1:0] cnt;
  logic             first_rep;

  logic [KEY_W-1:0] key_c;
  logic [CNT_W-1:0] cnt_nxt_c;
  logic             qualify_c;
  logic             load_c;
  logic [3:0]       dec_digit_c;
  logic             dec_blank_c;
  logic             dec_err_c;

  // Match counter update and qualify pulse for the current strobe
  always_comb begin
    key_c     = {over_in, seg_in};
    cnt_nxt_c = CNT_W'(1);
    if (key_c == cand) begin
      cnt_nxt_c = (cnt < CNT_MAX) ? cnt + CNT_W'(1) : cnt;
    end
    qualify_c = sample_en && (cnt_nxt_c == CNT_MAX) &&
                ((key_c != last_rep) || first_rep);
    load_c    = qualify_c && ((state == S_EMPTY) || out_ready);
  end

  // Segment pattern to digit decode
  always_comb begin
    dec_digit_c = 4'hF;
    dec_blank_c = 1'b0;
    dec_err_c   = 1'b0;
    case (seg_in)
      7'h3F: dec_digit_c = 4'd0;
      7'h06: dec_digit_c = 4'd1;
      7'h5B: dec_digit_c = 4'd2;
      7'h4F: dec_digit_c = 4'd3;
      7'h66: dec_digit_c = 4'd4;
      7'h6D: dec_digit_c = 4'd5;
      7'h7D: dec_digit_c = 4'd6;
      7'h07: dec_digit_c = 4'd7;
      7'h7F: dec_digit_c = 4'd8;
      7'h67: dec_digit_c = 4'd9;
      7'h00: begin
        dec_digit_c = 4'd0;
        dec_blank_c = 1'b1;
      end
      default: dec_err_c = 1'b1;
    endcase
  end

  // Candidate tracking, report dedup, and output hold FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      cand      <= '0;
      cnt       <= '0;
      last_rep  <= '0;
      first_rep <= 1'b1;
      out_valid <= 1'b0;
      out_digit <= 4'h0;
      out_blank <= 1'b0;
      out_err   <= 1'b0;
      out_over  <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (sample_en) begin
        cand <= key_c;
        cnt  <= cnt_nxt_c;
      end
      if (qualify_c) begin
        last_rep  <= key_c;
        first_rep <= 1'b0;
      end
      if (load_c) begin
        out_digit <= dec_digit_c;
        out_blank <= dec_blank_c;
        out_err   <= dec_err_c;
        out_over  <= over_in;
      end
      case (state)
        S_EMPTY: begin
          if (load_c) begin
            state     <= S_HOLD;
            out_valid <= 1'b1;
          end
        end
        S_HOLD: begin
          if (out_ready && !qualify_c) begin
            state     <= S_EMPTY;
            out_valid <= 1'b0;
          end else if (!out_ready && qualify_c) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state     <= S_EMPTY;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_decoder_rx.sv
// Bench for seg7_decoder_rx: driver feeds stimulus and a reference model pushes
// expected results; a negedge monitor pops and compares each presented result.
module tb_seg7_decoder_rx;

  localparam int unsigned STABLE_N = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       sample_en;
  logic [6:0] seg_in;
  logic       over_in;
  logic       out_ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_err;
  logic       out_over;
  logic       overrun;

  seg7_decoder_rx #(.STABLE_N(STABLE_N), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .sample_en(sample_en), .seg_in(seg_in),
    .over_in(over_in), .out_ready(out_ready), .out_valid(out_valid),
    .out_digit(out_digit), .out_blank(out_blank), .out_err(out_err),
    .out_over(out_over), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  digit;
    logic        blank;
    logic        err;
    logic        over;
  } exp_t;

  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state (predicts the edge following each driven step)
  logic [7:0] m_prev  = 8'h00;
  int         m_run   = 0;
  logic [7:0] m_last  = 8'h00;
  bit         m_first = 1'b1;
  bit         m_full  = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_full_cur = 1'b0;
  bit         m_ovr_cur  = 1'b0;

  function automatic exp_t ref_decode(input logic [7:0] key);
    logic [6:0] tbl [10];
    exp_t r;
    tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67};
    r.cyc   = 0;
    r.over  = key[7];
    r.blank = (key[6:0] == 7'h00);
    r.err   = !r.blank;
    r.digit = r.blank ? 4'h0 : 4'hF;
    for (int i = 0; i < 10; i++) begin
      if (tbl[i] == key[6:0]) begin
        r.digit = 4'(i);
        r.err   = 1'b0;
      end
    end
    return r;
  endfunction

  task automatic step(input bit r, input bit en, input logic [6:0] s,
                      input bit ov, input bit rdy);
    logic [7:0] key;
    bit         q;
    exp_t       e;
    @(posedge clk);
    #2;
    m_full_cur = m_full;
    m_ovr_cur  = m_ovr;
    rst = r; sample_en = en; seg_in = s; over_in = ov; out_ready = rdy;
    q = 1'b0;
    if (r) begin
      m_prev = 8'h00; m_run = 0; m_last = 8'h00; m_first = 1'b1;
      m_full = 1'b0;  m_ovr = 1'b0;
    end else begin
      if (en) begin
        key    = {ov, s};
        m_run  = (key == m_prev) ? ((m_run + 1 > STABLE_N) ? STABLE_N : m_run + 1) : 1;
        m_prev = key;
        q = (m_run == STABLE_N) && ((key != m_last) || m_first);
        if (q) begin
          m_last  = key;
          m_first = 1'b0;
        end
      end
      if (q) begin
        if (!m_full || rdy) begin
          e = ref_decode(key);
          e.cyc = cyc + 1;
          sb.push_back(e);
          m_full = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_full && rdy) begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic strobes(input int n, input logic [6:0] s, input bit ov, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, s, ov, rdy);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 7'h00, 1'b0, rdy);
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    tests++;
    if ({out_valid, out_digit, out_blank, out_err, out_over, overrun} !== 9'h000) begin
      fails++;
      $display("FAIL %s: got valid=%b digit=%h blank=%b err=%b over=%b overrun=%b, want all 0",
               name, out_valid, out_digit, out_blank, out_err, out_over, overrun);
    end
  endtask

  // Monitor: track valid/overrun against the model and score each new result
  bit pv = 1'b0;
  bit pa = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    tests++;
    if (out_valid !== m_full_cur || overrun !== m_ovr_cur) begin
      fails++;
      $display("FAIL state@%0d: valid=%b overrun=%b, want valid=%b overrun=%b",
               cyc, out_valid, overrun, m_full_cur, m_ovr_cur);
    end
    if (out_valid === 1'b1 && (!pv || pa)) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL spurious@%0d: digit=%h blank=%b err=%b over=%b, want no result",
                 cyc, out_digit, out_blank, out_err, out_over);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || out_digit !== e.digit || out_blank !== e.blank ||
            out_err !== e.err || out_over !== e.over) begin
          fails++;
          $display("FAIL result: got cyc=%0d digit=%h blank=%b err=%b over=%b, want cyc=%0d digit=%h blank=%b err=%b over=%b",
                   cyc, out_digit, out_blank, out_err, out_over,
                   e.cyc, e.digit, e.blank, e.err, e.over);
        end
      end
    end
    pv = (out_valid === 1'b1);
    pa = (out_valid === 1'b1) && (out_ready === 1'b1);
  end

  initial begin
    logic [6:0] pool [14];
    logic [6:0] s;
    bit         ov;
    int         n;
    pool = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h67,
             7'h00, 7'h49, 7'h01, 7'h7E};
    rst = 1'b1; sample_en = 1'b0; seg_in = 7'h00; over_in = 1'b0; out_ready = 1'b0;

    // 1: basic qualify and accept
    step(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
    step(1'b0, 1'b0, 7'h00, 1'b0, 1'b0);
    check_reset_state("reset_initial");
    strobes(3, 7'h5B, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // 2: short run then qualifying run
    strobes(2, 7'h5B, 1'b0, 1'b1);
    strobes(3, 7'h4F, 1'b0, 1'b1);
    idle(2, 1'b1);

    // 3: long hold reports once, with overflow
    strobes(6, 7'h7F, 1'b1, 1'b1);
    idle(2, 1'b1);

    // 4: overrun while consumer stalls
    strobes(3, 7'h06, 1'b0, 1'b0);
    strobes(3, 7'h66, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);

    // 5: blank and error patterns
    strobes(3, 7'h00, 1'b0, 1'b1);
    idle(1, 1'b1);
    strobes(3, 7'h49, 1'b0, 1'b1);
    idle(2, 1'b1);

    // 6: reset mid-qualification, then fresh strobes
    strobes(2, 7'h6D, 1'b0, 1'b1);
    step(1'b1, 1'b0, 7'h00, 1'b0, 1'b1);
    step(1'b0, 1'b1, 7'h6D, 1'b0, 1'b1);
    check_reset_state("reset_midqual");
    idle(3, 1'b1);
    strobes(2, 7'h6D, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Back-to-back load: accept coincides with a new qualify
    strobes(3, 7'h07, 1'b0, 1'b0);
    strobes(2, 7'h67, 1'b0, 1'b0);
    step(1'b0, 1'b1, 7'h67, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Same pattern returns after another qualified
    strobes(3, 7'h3F, 1'b0, 1'b1);
    strobes(3, 7'h06, 1'b0, 1'b1);
    strobes(3, 7'h3F, 1'b0, 1'b1);
    idle(2, 1'b1);

    // Randomized runs with gaps, stalls and occasional reset
    for (int k = 0; k < 600; k++) begin
      s  = pool[$urandom_range(13)];
      ov = ($urandom_range(7) == 0);
      n  = $urandom_range(5, 1);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(199) == 0)
          step(1'b1, 1'b0, 7'h00, 1'b0, 1'b0);
        else if ($urandom_range(3) == 0)
          step(1'b0, 1'b0, 7'(~s), 1'b0, 1'($urandom_range(1)));
        else
          step(1'b0, 1'b1, s, ov, 1'($urandom_range(1)));
      end
    end

    idle(6, 1'b1);
    @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expected results never presented, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
